// File: rtl/kmu_launch_queue_pkg.sv
// kmu_launch_queue_pkg: launch descriptor type and DCR register map shared by the launch queue.
package kmu_launch_queue_pkg;
  localparam int KMU_MAX_DIMS = 3;
  localparam int KMU_DATA_WIDTH = 32;
  localparam int STARTUP_ADDR0 = 'h001;
  localparam int STARTUP_ARG0 = 'h003;
  localparam int GRID_DIM0 = 'h010;
  localparam int BLOCK_DIM0 = 'h013;
  typedef struct packed {
    logic [KMU_DATA_WIDTH-1:0] pc;
    logic [KMU_DATA_WIDTH-1:0] param;
    logic [KMU_MAX_DIMS-1:0][KMU_DATA_WIDTH-1:0] grid_dim;
    logic [KMU_MAX_DIMS-1:0][KMU_DATA_WIDTH-1:0] block_dim;
  } kmu_launch_desc_t;
endpackage

// File: rtl/kmu_desc_fifo.sv
// kmu_desc_fifo: register-array FIFO of launch descriptors; a push is accepted when full if a pop happens in the same cycle.
module kmu_desc_fifo
  import kmu_launch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  kmu_launch_desc_t push_data,
  input  logic             pop,
  output kmu_launch_desc_t head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  kmu_launch_desc_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/kmu_launch_queue.sv
// kmu_launch_queue: DCR-staged kernel launch descriptors queued for the KMU; KMU_LAUNCH_QUEUE_PERF_EN adds perf counters.
module kmu_launch_queue
  import kmu_launch_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int NUM_DIMS = 3,
  parameter int DCR_ADDR_WIDTH = 12,
  parameter int DCR_DATA_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               dcr_write_valid,
  input  logic [DCR_ADDR_WIDTH-1:0]          dcr_write_addr,
  input  logic [DCR_DATA_WIDTH-1:0]          dcr_write_data,
  output logic                               kmu_valid,
  input  logic                               kmu_ready,
  output logic [DCR_DATA_WIDTH-1:0]          kmu_pc,
  output logic [DCR_DATA_WIDTH-1:0]          kmu_param,
  output logic [NUM_DIMS*DCR_DATA_WIDTH-1:0] kmu_grid_dim,
  output logic [NUM_DIMS*DCR_DATA_WIDTH-1:0] kmu_block_dim,
  input  logic                               kmu_busy,
  output logic                               busy,
  output logic                               overflow,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count
`ifdef KMU_LAUNCH_QUEUE_PERF_EN
  ,
  output logic [31:0]                        perf_launches,
  output logic [31:0]                        perf_drops,
  output logic [31:0]                        perf_stall_cycles
`endif
);
  logic [KMU_DATA_WIDTH-1:0] stage_pc;
  logic [KMU_MAX_DIMS-1:0][KMU_DATA_WIDTH-1:0] stage_grid, stage_block;
  kmu_launch_desc_t push_desc, head;
  logic commit, pop, full, empty, drop;
  assign commit = dcr_write_valid && dcr_write_addr == DCR_ADDR_WIDTH'(STARTUP_ARG0);
  assign pop = kmu_valid && kmu_ready;
  assign drop = commit && full && !pop;
  assign push_desc = '{pc: stage_pc, param: dcr_write_data, grid_dim: stage_grid, block_dim: stage_block};
  assign kmu_valid = !empty;
  assign kmu_pc = head.pc;
  assign kmu_param = head.param;
  assign kmu_grid_dim = head.grid_dim[NUM_DIMS-1:0];
  assign kmu_block_dim = head.block_dim[NUM_DIMS-1:0];
  assign busy = !empty || kmu_busy;
  // Dimensions at or above NUM_DIMS are never written, so they stay zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_pc <= '0;
      stage_grid <= '0;
      stage_block <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (dcr_write_valid) begin
        if (dcr_write_addr == DCR_ADDR_WIDTH'(STARTUP_ADDR0)) stage_pc <= dcr_write_data;
        for (int i = 0; i < NUM_DIMS; i++) begin
          if (dcr_write_addr == DCR_ADDR_WIDTH'(GRID_DIM0 + i)) stage_grid[i] <= dcr_write_data;
          if (dcr_write_addr == DCR_ADDR_WIDTH'(BLOCK_DIM0 + i)) stage_block[i] <= dcr_write_data;
        end
      end
    end
  end
  kmu_desc_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(commit),
    .push_data(push_desc),
    .pop(pop),
    .head(head),
    .full(full),
    .empty(empty),
    .count(queue_count)
  );
`ifdef KMU_LAUNCH_QUEUE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_launches <= '0;
      perf_drops <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (pop) perf_launches <= perf_launches + 32'd1;
      if (drop) perf_drops <= perf_drops + 32'd1;
      if (kmu_valid && !kmu_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_kmu_launch_queue.sv
// tb_kmu_launch_queue: vector table plus scoreboard bench for kmu_launch_queue (3-dim and 2-dim instances).
module tb_kmu_launch_queue;
  localparam logic [11:0] A_PC = 12'h001, A_ARG = 12'h003, A_G0 = 12'h010, A_G1 = 12'h011, A_G2 = 12'h012;
  localparam logic [11:0] A_B0 = 12'h013, A_B1 = 12'h014, A_B2 = 12'h015, A_BAD = 12'hFFF;
  logic clk = 0, reset = 1, dcr_write_valid = 0, kmu_ready = 0, kmu_busy = 0;
  logic [11:0] dcr_write_addr = '0;
  logic [31:0] dcr_write_data = '0;
  logic kmu_valid, busy, overflow, n2_valid, n2_busy, n2_overflow;
  logic [31:0] kmu_pc, kmu_param, n2_pc, n2_param;
  logic [95:0] kmu_grid_dim, kmu_block_dim;
  logic [63:0] n2_grid, n2_block;
  logic [2:0] queue_count, n2_count;
`ifdef KMU_LAUNCH_QUEUE_PERF_EN
  logic [31:0] perf_launches, perf_drops, perf_stall_cycles, n2_launches, n2_drops, n2_stalls;
`endif
  always #5 clk = ~clk;
  kmu_launch_queue dut (
    .clk(clk), .reset(reset), .dcr_write_valid(dcr_write_valid), .dcr_write_addr(dcr_write_addr),
    .dcr_write_data(dcr_write_data), .kmu_valid(kmu_valid), .kmu_ready(kmu_ready), .kmu_pc(kmu_pc),
    .kmu_param(kmu_param), .kmu_grid_dim(kmu_grid_dim), .kmu_block_dim(kmu_block_dim), .kmu_busy(kmu_busy),
    .busy(busy), .overflow(overflow), .queue_count(queue_count)
`ifdef KMU_LAUNCH_QUEUE_PERF_EN
    , .perf_launches(perf_launches), .perf_drops(perf_drops), .perf_stall_cycles(perf_stall_cycles)
`endif
  );
  kmu_launch_queue #(.NUM_DIMS(2)) dut2 (
    .clk(clk), .reset(reset), .dcr_write_valid(dcr_write_valid), .dcr_write_addr(dcr_write_addr),
    .dcr_write_data(dcr_write_data), .kmu_valid(n2_valid), .kmu_ready(kmu_ready), .kmu_pc(n2_pc),
    .kmu_param(n2_param), .kmu_grid_dim(n2_grid), .kmu_block_dim(n2_block), .kmu_busy(kmu_busy),
    .busy(n2_busy), .overflow(n2_overflow), .queue_count(n2_count)
`ifdef KMU_LAUNCH_QUEUE_PERF_EN
    , .perf_launches(n2_launches), .perf_drops(n2_drops), .perf_stall_cycles(n2_stalls)
`endif
  );
  typedef struct {logic [31:0] pc, param; logic [95:0] grid, block;} desc_t;
  typedef struct {bit wv; logic [11:0] a; logic [31:0] d; bit rdy, kb, ev; int ec; bit eb;} vec_t;
  desc_t q[$];
  logic [31:0] m_pc;
  logic [95:0] m_grid, m_block;
  bit m_ovf;
  int unsigned m_launch, m_drop, m_stall;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string n, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic check();
    chk("valid", kmu_valid, q.size() != 0);
    chk("count", queue_count, q.size());
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, q.size() != 0 || kmu_busy);
    chk("n2_valid", n2_valid, q.size() != 0);
    chk("n2_count", n2_count, q.size());
    chk("n2_overflow", n2_overflow, m_ovf);
    if (q.size() != 0) begin
      chk("pc", kmu_pc, q[0].pc);
      chk("param", kmu_param, q[0].param);
      chk("grid", kmu_grid_dim, q[0].grid);
      chk("block", kmu_block_dim, q[0].block);
      chk("n2_param", n2_param, q[0].param);
      chk("n2_grid", n2_grid, q[0].grid[63:0]);
      chk("n2_block", n2_block, q[0].block[63:0]);
    end
`ifdef KMU_LAUNCH_QUEUE_PERF_EN
    chk("perf_launches", perf_launches, m_launch);
    chk("perf_drops", perf_drops, m_drop);
    chk("perf_stall", perf_stall_cycles, m_stall);
`endif
  endtask
  task automatic cyc(input bit wv, input logic [11:0] a, input logic [31:0] d, input bit rdy, input bit kb);
    bit pop, full;
    dcr_write_valid = wv;
    dcr_write_addr = a;
    dcr_write_data = d;
    kmu_ready = rdy;
    kmu_busy = kb;
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_pc = '0; m_grid = '0; m_block = '0; m_ovf = 0;
      m_launch = 0; m_drop = 0; m_stall = 0;
    end else begin
      pop = rdy && q.size() != 0;
      full = q.size() == 4;
      if (q.size() != 0 && !rdy) m_stall++;
      if (pop) begin
        void'(q.pop_front());
        m_launch++;
      end
      if (wv) begin
        if (a == A_PC) m_pc = d;
        if (a >= A_G0 && a <= A_G2) m_grid[32*(a-A_G0) +: 32] = d;
        if (a >= A_B0 && a <= A_B2) m_block[32*(a-A_B0) +: 32] = d;
        if (a == A_ARG) begin
          if (!full || pop) q.push_back('{m_pc, d, m_grid, m_block});
          else begin
            m_ovf = 1;
            m_drop++;
          end
        end
      end
    end
    @(negedge clk);
    check();
  endtask
  vec_t tv[10];
  logic [31:0] pop_exp[4];
  logic [31:0] s0;
  initial begin
    tv[0] = '{1, A_PC, 32'h80000000, 1, 0, 0, 0, 0};
    tv[1] = '{1, A_G0, 32'd4, 1, 0, 0, 0, 0};
    tv[2] = '{1, A_G1, 32'd2, 1, 0, 0, 0, 0};
    tv[3] = '{1, A_G2, 32'd1, 1, 0, 0, 0, 0};
    tv[4] = '{1, A_B0, 32'd64, 1, 0, 0, 0, 0};
    tv[5] = '{1, A_B1, 32'd1, 1, 0, 0, 0, 0};
    tv[6] = '{1, A_B2, 32'd1, 1, 0, 0, 0, 0};
    tv[7] = '{1, A_ARG, 32'h1000, 1, 0, 1, 1, 1};
    tv[8] = '{0, 12'h000, 32'h0, 1, 1, 0, 0, 1};
    tv[9] = '{0, 12'h000, 32'h0, 0, 0, 0, 0, 0};
    pop_exp = '{32'h20, 32'h30, 32'h40, 32'h99};
    reset = 1;
    cyc(0, 0, 0, 0, 1);
    chk("rst_busy_follows_kmu_busy", busy, 1);
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(tv[i].wv, tv[i].a, tv[i].d, tv[i].rdy, tv[i].kb);
      chk($sformatf("vec%0d_valid", i), kmu_valid, tv[i].ev);
      chk($sformatf("vec%0d_count", i), queue_count, tv[i].ec);
      chk($sformatf("vec%0d_busy", i), busy, tv[i].eb);
      if (i == 7) begin
        chk("t1_pc", kmu_pc, 32'h80000000);
        chk("t1_grid", kmu_grid_dim, {32'd1, 32'd2, 32'd4});
        chk("t1_block", kmu_block_dim, {32'd1, 32'd1, 32'd64});
      end
    end
    reset = 1;
    cyc(0, 0, 0, 0, 0);
    reset = 0;
    for (int p = 1; p <= 5; p++) cyc(1, A_ARG, 32'(p * 16), 0, 0);
    chk("full_count", queue_count, 4);
    chk("overflow_set", overflow, 1);
    chk("full_head", kmu_param, 32'h10);
    cyc(1, A_ARG, 32'h99, 1, 0);
    chk("push_pop_full_count", queue_count, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pop_order%0d", i), kmu_param, pop_exp[i]);
      cyc(0, 0, 0, 1, 0);
    end
    chk("drained_count", queue_count, 0);
    chk("overflow_sticky", overflow, 1);
    cyc(1, A_PC, 32'h100, 0, 0);
    cyc(1, A_ARG, 32'h1, 0, 0);
    cyc(1, A_ARG, 32'h2, 0, 0);
    cyc(1, A_G2, 32'd7, 0, 0);
    cyc(1, A_BAD, 32'hDEADBEEF, 0, 0);
`ifdef KMU_LAUNCH_QUEUE_PERF_EN
    s0 = perf_stall_cycles;
`endif
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
    chk("stable_pc", kmu_pc, 32'h100);
    chk("stable_param", kmu_param, 32'h1);
`ifdef KMU_LAUNCH_QUEUE_PERF_EN
    chk("stall_10", perf_stall_cycles - s0, 10);
`endif
    cyc(0, 0, 0, 1, 0);
    chk("keep_pc", kmu_pc, 32'h100);
    chk("keep_param", kmu_param, 32'h2);
    chk("keep_grid", kmu_grid_dim, 96'h0);
    cyc(1, A_ARG, 32'h3, 0, 0);
    cyc(1, A_ARG, 32'h4, 0, 0);
    chk("three_queued", queue_count, 3);
    reset = 1;
    cyc(0, 0, 0, 0, 0);
    reset = 0;
    chk("rst_valid", kmu_valid, 0);
    chk("rst_count", queue_count, 0);
    chk("rst_overflow", overflow, 0);
    cyc(1, A_ARG, 32'h55, 0, 0);
    chk("post_rst_pc", kmu_pc, 32'h0);
    chk("post_rst_grid", kmu_grid_dim, 96'h0);
    chk("post_rst_n2_pc", n2_pc, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/kmu_launch_queue.md
Name: kmu_launch_queue

Overview:
- DCR-programmed kernel-launch command processor feeding the KMU.
- DCR writes fill a staging descriptor: pc, param, grid_dim[NUM_DIMS], block_dim[NUM_DIMS]. A write to the commit register (STARTUP_ARG0) snapshots the descriptor into a QUEUE_DEPTH-entry FIFO.
- The FIFO head is offered to the KMU over a valid/ready handshake, so the host can queue several launches back to back without waiting.
- Sits between the DCR bus slave and the KMU; busy feeds the top-level busy aggregation.

Parameters:
- QUEUE_DEPTH, 4, descriptor FIFO entries; power of two, >= 2.
- NUM_DIMS, 3, grid/block dimensions; 1..3.
- DCR_ADDR_WIDTH, 12, DCR address width.
- DCR_DATA_WIDTH, 32, DCR data width and width of every descriptor field.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- dcr_write_valid  in  1  DCR write strobe
- dcr_write_addr  in  DCR_ADDR_WIDTH  DCR address
- dcr_write_data  in  DCR_DATA_WIDTH  DCR data
- kmu_valid  out  1  head descriptor valid
- kmu_ready  in  1  KMU accepts head
- kmu_pc  out  DCR_DATA_WIDTH  head kernel PC
- kmu_param  out  DCR_DATA_WIDTH  head kernel argument pointer
- kmu_grid_dim  out  NUM_DIMS*DCR_DATA_WIDTH  head grid dims; dim0 in LSBs
- kmu_block_dim  out  NUM_DIMS*DCR_DATA_WIDTH  head block dims; dim0 in LSBs
- kmu_busy  in  1  KMU still dispatching
- busy  out  1  queue non-empty or kmu_busy
- overflow  out  1  sticky: a commit was dropped because the queue was full
- queue_count  out  $clog2(QUEUE_DEPTH+1)  occupied entries

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Reset values:
  - kmu_valid=0, queue_count=0, overflow=0.
  - All staging fields 0; FIFO pointers 0.
  - busy=kmu_busy (combinational).
  - Reset mid-operation discards all queued descriptors and all staged values.
- Staging decode (on dcr_write_valid):
  - STARTUP_ADDR0 -> pc.
  - GRID_DIM0..2 -> grid_dim[0..2].
  - BLOCK_DIM0..2 -> block_dim[0..2].
  - Dimension addresses with index >= NUM_DIMS are ignored.
  - Unknown addresses are ignored; no state change.
- Staging retention: staged values persist across commits. A second launch need only rewrite the fields that change.
- Commit:
  - A write to STARTUP_ARG0 pushes {staged pc, dcr_write_data as param, staged grid/block dims}.
  - The descriptor pushed is the one whose param is the write data of that same cycle.
- Push latency: commit at cycle N with queue empty -> kmu_valid=1 at N+1 with that descriptor. There is no combinational DCR-to-KMU path.
- Handshake:
  - Pop when kmu_valid && kmu_ready.
  - Head outputs are stable while kmu_valid=1 and kmu_ready=0.
  - kmu_valid never drops without a pop.
- Full queue:
  - A commit while queue_count==QUEUE_DEPTH and no pop in the same cycle is dropped.
  - The drop sets overflow; overflow clears only on reset.
  - A commit in the same cycle as a pop on a full queue is accepted; count is unchanged.
- Empty queue: a commit with a simultaneous kmu_ready is legal; nothing is popped that cycle.
- queue_count: +1 on accepted push, -1 on pop, unchanged on both or neither.
- Pointers: wrap modulo QUEUE_DEPTH.
- Staging write in the commit cycle: a staging write to a non-commit address takes effect for the next commit only. This holds trivially because the DCR bus carries one address per cycle.
- busy: (queue_count!=0) || kmu_busy.

Optional Feature:
- Macro: KMU_LAUNCH_QUEUE_PERF_EN.
- With the macro defined, three extra outputs are added:
  - perf_launches (32b): increments on each pop.
  - perf_drops (32b): increments on each dropped commit.
  - perf_stall_cycles (32b): increments each cycle with kmu_valid && !kmu_ready.
  - All three reset to 0 and wrap on overflow.
- Without the macro, these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- The shared package VX_gpu_pkg gains:
  - kmu_launch_desc_t: packed struct {pc, param, grid_dim[NUM_DIMS], block_dim[NUM_DIMS]}.
  - Constant KMU_MAX_DIMS=3.
- The DCR address macros (STARTUP_ADDR0/ARG0, GRID_DIM0..2, BLOCK_DIM0..2) stay in VX_define.vh.
- One sub-module is natural: kmu_desc_fifo.
  - Generic registered-output FIFO of kmu_launch_desc_t.
  - Provides push/pop/full/empty/count and supports same-cycle push+pop when full.
- Decode and staging stay in the top module.

Test Plan:
- Write pc=0x80000000, grid={4,2,1}, block={64,1,1}, then ARG0=0x1000 with kmu_ready=1 -> kmu_valid at +1 cycle with exactly those fields; popped; busy falls when kmu_busy=0.
- kmu_ready=0 and 5 commits with param 0x10..0x50 at QUEUE_DEPTH=4 -> queue_count=4, overflow=1, 0x50 lost. Then ready=1 -> pops 0x10,0x20,0x30,0x40 in order.
- Full queue, commit param 0x99 in the same cycle as a pop -> accepted, count stays 4, 0x99 emerges last.
- Commit A (pc=0x100), rewrite only param via ARG0=0x2 -> second descriptor keeps pc=0x100 and dims from A.
- Write GRID_DIM2=7 with NUM_DIMS=2, and write unknown address 0xFFF -> no descriptor change. Hold kmu_ready=0 for 10 cycles -> head stable; with PERF_EN, perf_stall_cycles=10.
- Reset asserted with 3 entries queued -> next cycle kmu_valid=0, queue_count=0, overflow=0, and a following commit carries pc=0.
